// File: rtl/lcd_bus.sv
// HD44780-style parallel LCD bus master: one command per transfer, optional busy-flag polling.
// Supports 8-bit or 4-bit (nibble, high first) buses with programmable setup/pulse/hold timing.
module lcd_bus #(
  parameter int BUS_WIDTH    = 8,
  parameter int SETUP_CYCLES = 1,
  parameter int PULSE_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int BUSY_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_rs,
  input  logic                 cmd_read,
  input  logic [7:0]           cmd_data,
  input  logic                 cmd_wait_busy,
  output logic                 rsp_valid,
  output logic [7:0]           rsp_data,
  output logic                 timeout,
  output logic                 rs_pin,
  output logic                 rw_pin,
  output logic                 e_pin,
  output logic [BUS_WIDTH-1:0] db_out,
  output logic                 db_oe,
  input  logic [BUS_WIDTH-1:0] db_in
);

  localparam int CNT_MAX = (SETUP_CYCLES > PULSE_CYCLES) ?
                           ((SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES) :
                           ((PULSE_CYCLES > HOLD_CYCLES) ? PULSE_CYCLES : HOLD_CYCLES);
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int PW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, PULSE, HOLD, POLL_SETUP, POLL_PULSE, POLL_HOLD
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [PW-1:0]   poll_reg, poll_next;
  logic            nib_reg, nib_next;
  logic            rs_reg, rs_next;
  logic            read_reg, read_next;
  logic            wait_reg, wait_next;
  logic [7:0]      data_reg, data_next;
  logic [7:0]      rd_reg, rd_next;
  logic            busy_reg, busy_next;
  logic            rsp_valid_reg, rsp_valid_next;
  logic            timeout_reg, timeout_next;

  logic                 setup_done, pulse_done, hold_done;
  logic                 last_phase, busy_bit;
  logic [BUS_WIDTH-1:0] wr_val;
  logic [7:0]           rd_sample;

  assign setup_done = (cnt_reg == CW'(SETUP_CYCLES - 1));
  assign pulse_done = (cnt_reg == CW'(PULSE_CYCLES - 1));
  assign hold_done  = (cnt_reg == CW'(HOLD_CYCLES - 1));

  generate
    if (BUS_WIDTH == 8) begin : g_byte
      assign wr_val     = data_reg;
      assign rd_sample  = db_in;
      assign last_phase = 1'b1;
      assign busy_bit   = db_in[7];
    end else begin : g_nibble
      assign wr_val     = nib_reg ? data_reg[3:0] : data_reg[7:4];
      assign rd_sample  = nib_reg ? {rd_reg[7:4], db_in} : {db_in, rd_reg[3:0]};
      assign last_phase = nib_reg;
      assign busy_bit   = db_in[3];
    end
  endgenerate

  // Reset lands in POLL_SETUP: its pin values equal the reset values, and the
  // panel must report not-busy before the first command is taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= POLL_SETUP;
      cnt_reg       <= '0;
      poll_reg      <= '0;
      nib_reg       <= 1'b0;
      rs_reg        <= 1'b0;
      read_reg      <= 1'b0;
      wait_reg      <= 1'b0;
      data_reg      <= 8'h00;
      rd_reg        <= 8'h00;
      busy_reg      <= 1'b0;
      rsp_valid_reg <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      cnt_reg       <= cnt_next;
      poll_reg      <= poll_next;
      nib_reg       <= nib_next;
      rs_reg        <= rs_next;
      read_reg      <= read_next;
      wait_reg      <= wait_next;
      data_reg      <= data_next;
      rd_reg        <= rd_next;
      busy_reg      <= busy_next;
      rsp_valid_reg <= rsp_valid_next;
      timeout_reg   <= timeout_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    poll_next      = poll_reg;
    nib_next       = nib_reg;
    rs_next        = rs_reg;
    read_next      = read_reg;
    wait_next      = wait_reg;
    data_next      = data_reg;
    rd_next        = rd_reg;
    busy_next      = busy_reg;
    rsp_valid_next = 1'b0;
    timeout_next   = timeout_reg;
    case (state_reg)
      IDLE: begin
        if (cmd_valid) begin
          rs_next      = cmd_rs;
          read_next    = cmd_read;
          data_next    = cmd_data;
          wait_next    = cmd_wait_busy;
          timeout_next = 1'b0;
          cnt_next     = '0;
          nib_next     = 1'b0;
          state_next   = SETUP;
        end
      end
      SETUP, POLL_SETUP: begin
        if (setup_done) begin
          cnt_next   = '0;
          state_next = (state_reg == SETUP) ? PULSE : POLL_PULSE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      PULSE: begin
        if (pulse_done) begin
          cnt_next   = '0;
          state_next = HOLD;
          if (read_reg) rd_next = rd_sample;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      POLL_PULSE: begin
        if (pulse_done) begin
          cnt_next   = '0;
          state_next = POLL_HOLD;
          // Busy flag lives in the first nibble only; the second is clocked out and dropped.
          if (!nib_reg) busy_next = busy_bit;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      HOLD: begin
        if (hold_done) begin
          cnt_next = '0;
          if (!last_phase) begin
            nib_next   = 1'b1;
            state_next = SETUP;
          end else begin
            nib_next = 1'b0;
            if (wait_reg) begin
              poll_next  = '0;
              state_next = POLL_SETUP;
            end else begin
              rsp_valid_next = read_reg;
              state_next     = IDLE;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      POLL_HOLD: begin
        if (hold_done) begin
          cnt_next = '0;
          if (!last_phase) begin
            nib_next   = 1'b1;
            state_next = POLL_SETUP;
          end else begin
            nib_next = 1'b0;
            if (busy_reg && (poll_reg == PW'(BUSY_TIMEOUT - 1))) begin
              timeout_next   = 1'b1;
              rsp_valid_next = read_reg;
              state_next     = IDLE;
            end else if (busy_reg) begin
              poll_next  = poll_reg + 1'b1;
              state_next = POLL_SETUP;
            end else begin
              rsp_valid_next = read_reg;
              state_next     = IDLE;
            end
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pins decode straight from registered state so an async reset drops E immediately.
  always_comb begin
    e_pin  = 1'b0;
    rs_pin = 1'b0;
    rw_pin = 1'b1;
    db_oe  = 1'b0;
    db_out = '0;
    case (state_reg)
      SETUP, PULSE, HOLD: begin
        e_pin  = (state_reg == PULSE);
        rs_pin = rs_reg;
        rw_pin = read_reg;
        db_oe  = ~read_reg;
        db_out = read_reg ? '0 : wr_val;
      end
      POLL_PULSE: e_pin = 1'b1;
      default: ;
    endcase
  end

  assign cmd_ready = (state_reg == IDLE);
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rd_reg;
  assign timeout   = timeout_reg;

endmodule
